// File: rtl/stv_io_ports_gen.sv
// stv_io_ports_gen: second-generation ST-V I/O port block.
// Byte-wide CS_N/RW_N register interface in front of up to 8 bidirectional
// ports, with synchronised and debounced pins, clear-on-read saturating coin
// counters and retriggerable coin-meter pulses.
module stv_io_ports_gen #(
  parameter int NUM_PORTS = 7,
  parameter int NUM_COIN  = 2,
  parameter int DEB_CYC   = 4,
  parameter int METER_LEN = 1024
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CE_R,
  input  logic [5:0]             A,
  input  logic [7:0]             DI,
  output logic [7:0]             DO,
  input  logic                   CS_N,
  input  logic                   RW_N,
  input  logic [8*NUM_PORTS-1:0] PIN_IN,
  output logic [8*NUM_PORTS-1:0] PIN_OUT,
  output logic [NUM_PORTS-1:0]   PIN_OE,
  input  logic [NUM_COIN-1:0]    COIN_N,
  output logic [NUM_COIN-1:0]    COIN_METER
);

  localparam int PB = 8 * NUM_PORTS;
  localparam int NB = PB + NUM_COIN;

  // Register addresses are {A,1'b1}, so decode is done on A alone.
  localparam logic [5:0]  A_DIR    = 6'd8;   // 0x11
  localparam logic [5:0]  A_COIN0  = 6'd9;   // 0x13
  localparam logic [5:0]  A_METER  = 6'd13;  // 0x1B
  localparam logic [15:0] METER_TC = 16'(METER_LEN);

  logic                rw_n_old;
  logic                cs_n_old;
  logic                wr_stb;
  logic                rd_stb;

  logic [NB-1:0]       raw;
  logic [NB-1:0]       sync1;
  logic [NB-1:0]       sync2;
  logic [NB-1:0]       deb;
  logic [PB-1:0]       deb_pin;
  logic [NUM_COIN-1:0] deb_coin;
  logic [NUM_COIN-1:0] coin_deb_d;
  logic [NUM_COIN-1:0] coin_fall;

  logic [7:0]          out_q     [NUM_PORTS];
  logic [7:0]          dir_q;
  logic [7:0]          coin_cnt  [NUM_COIN];
  logic [15:0]         meter_cnt [NUM_COIN];
  logic [7:0]          rd_val;

  // Bus strobes: write on RW_N falling while selected, read on CS_N falling while reading.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rw_n_old <= 1'b1;
      cs_n_old <= 1'b1;
    end else begin
      rw_n_old <= RW_N;
      cs_n_old <= CS_N;
    end
  end

  assign wr_stb = rw_n_old & ~RW_N & ~CS_N;
  assign rd_stb = cs_n_old & ~CS_N & RW_N;

  assign raw = {COIN_N, PIN_IN};

  // Two-flop synchroniser on every pin and coin switch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  generate
    if (DEB_CYC == 0) begin : g_deb_bypass
      assign deb = sync2;
    end else begin : g_deb
      localparam logic [3:0] DEB_TC = 4'(DEB_CYC);
      logic [3:0]    deb_cnt [NB];
      logic [NB-1:0] deb_q;

      // Per-bit debounce: accept a new level after DEB_CYC ticks of disagreement.
      always_ff @(posedge CLK) begin
        if (RST) begin
          deb_q <= '1;
          for (int b = 0; b < NB; b++) deb_cnt[b] <= 4'd0;
        end else begin
          for (int b = 0; b < NB; b++) begin
            if (sync2[b] == deb_q[b]) begin
              deb_cnt[b] <= 4'd0;
            end else if (CE_R) begin
              if (deb_cnt[b] + 4'd1 == DEB_TC) begin
                deb_q[b]   <= sync2[b];
                deb_cnt[b] <= 4'd0;
              end else begin
                deb_cnt[b] <= deb_cnt[b] + 4'd1;
              end
            end
          end
        end
      end

      assign deb = deb_q;
    end
  endgenerate

  assign deb_pin   = deb[PB-1:0];
  assign deb_coin  = deb[NB-1:PB];
  assign coin_fall = coin_deb_d & ~deb_coin;

  // Read mux; anything not backed by a readable register returns FF.
  always_comb begin
    rd_val = 8'hFF;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (A == 6'(i)) rd_val = deb_pin[8*i +: 8] & (out_q[i] | {8{dir_q[i]}});
    end
    if (A == A_DIR) rd_val = dir_q;
    for (int k = 0; k < NUM_COIN; k++) begin
      if (A == A_COIN0 + 6'(k)) rd_val = coin_cnt[k];
    end
  end

  // Port output latches, direction register and read data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_PORTS; i++) out_q[i] <= 8'hFF;
      dir_q <= 8'hFF;
      DO    <= 8'h00;
    end else begin
      if (wr_stb) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (A == 6'(i)) out_q[i] <= DI;
        end
        if (A == A_DIR) dir_q <= DI;
      end
      if (rd_stb) DO <= rd_val;
    end
  end

  // Coin counters: count debounced falling edges, saturate, clear on read.
  always_ff @(posedge CLK) begin
    if (RST) begin
      coin_deb_d <= '1;
      for (int k = 0; k < NUM_COIN; k++) coin_cnt[k] <= 8'h00;
    end else begin
      coin_deb_d <= deb_coin;
      for (int k = 0; k < NUM_COIN; k++) begin
        if (rd_stb && (A == A_COIN0 + 6'(k))) begin
          // An edge landing on the clearing read is kept, not lost.
          coin_cnt[k] <= {7'd0, coin_fall[k]};
        end else if (coin_fall[k] && (coin_cnt[k] != 8'hFF)) begin
          coin_cnt[k] <= coin_cnt[k] + 8'd1;
        end
      end
    end
  end

  // Coin-meter down-counters; a write reloads (retriggers) the pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < NUM_COIN; k++) meter_cnt[k] <= 16'd0;
    end else begin
      for (int k = 0; k < NUM_COIN; k++) begin
        if (wr_stb && (A == A_METER) && DI[k]) begin
          meter_cnt[k] <= METER_TC;
        end else if (meter_cnt[k] != 16'd0) begin
          meter_cnt[k] <= meter_cnt[k] - 16'd1;
        end
      end
    end
  end

  // Output packing.
  always_comb begin
    PIN_OUT    = '0;
    PIN_OE     = '0;
    COIN_METER = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      PIN_OUT[8*i +: 8] = out_q[i];
      PIN_OE[i]         = ~dir_q[i];
    end
    for (int k = 0; k < NUM_COIN; k++) COIN_METER[k] = (meter_cnt[k] != 16'd0);
  end

endmodule

// File: tb/tb_stv_io_ports_gen.sv
// tb_stv_io_ports_gen: directed plus randomized bench for stv_io_ports_gen,
// checked every cycle against a behavioural model of the port block.
module tb_stv_io_ports_gen;

  localparam int NP   = 7;
  localparam int NC   = 2;
  localparam int DEB  = 4;
  localparam int MLEN = 16;
  localparam int PB   = 8 * NP;
  localparam int NB   = PB + NC;

  logic          CLK = 1'b0;
  logic          RST;
  logic          CE_R;
  logic [5:0]    A;
  logic [7:0]    DI;
  logic [7:0]    DO;
  logic          CS_N;
  logic          RW_N;
  logic [PB-1:0] PIN_IN;
  logic [PB-1:0] PIN_OUT;
  logic [NP-1:0] PIN_OE;
  logic [NC-1:0] COIN_N;
  logic [NC-1:0] COIN_METER;

  int errors = 0;
  int checks = 0;

  stv_io_ports_gen #(
    .NUM_PORTS(NP), .NUM_COIN(NC), .DEB_CYC(DEB), .METER_LEN(MLEN)
  ) dut (
    .CLK(CLK), .RST(RST), .CE_R(CE_R), .A(A), .DI(DI), .DO(DO),
    .CS_N(CS_N), .RW_N(RW_N), .PIN_IN(PIN_IN), .PIN_OUT(PIN_OUT),
    .PIN_OE(PIN_OE), .COIN_N(COIN_N), .COIN_METER(COIN_METER)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_started = 0;
  bit         m_rw_old, m_cs_old;
  bit         m_s1 [NB];
  bit         m_s2 [NB];
  bit         m_deb [NB];
  int         m_run [NB];      // consecutive CE_R ticks the input has disagreed
  bit         m_coin_prev [NC];
  int         m_coin [NC];
  int         m_meter [NC];
  logic [7:0] m_out [NP];
  logic [7:0] m_dir;
  logic [7:0] m_do;

  function automatic logic [7:0] model_read(input int addr);
    logic [7:0] v;
    int i;
    if (addr < 1 + 2 * NP) begin
      i = (addr - 1) / 2;
      for (int j = 0; j < 8; j++) v[j] = m_deb[8*i + j];
      return v & (m_out[i] | (m_dir[i] ? 8'hFF : 8'h00));
    end
    if (addr == 'h11) return m_dir;
    for (int k = 0; k < NC; k++) if (addr == 'h13 + 2 * k) return 8'(m_coin[k]);
    return 8'hFF;
  endfunction

  int         mv_addr;
  bit         mv_wr, mv_rd;
  logic [7:0] mv_rv;
  bit         mv_fall [NC];

  always @(posedge CLK) begin
    if (RST) begin
      m_started = 1;
      m_rw_old  = 1;
      m_cs_old  = 1;
      for (int b = 0; b < NB; b++) begin
        m_s1[b] = 1; m_s2[b] = 1; m_deb[b] = 1; m_run[b] = 0;
      end
      for (int k = 0; k < NC; k++) begin
        m_coin_prev[k] = 1; m_coin[k] = 0; m_meter[k] = 0;
      end
      for (int i = 0; i < NP; i++) m_out[i] = 8'hFF;
      m_dir = 8'hFF;
      m_do  = 8'h00;
    end else begin
      mv_addr = 2 * int'(A) + 1;
      mv_wr   = m_rw_old && !RW_N && !CS_N;
      mv_rd   = m_cs_old && !CS_N && RW_N;
      mv_rv   = model_read(mv_addr);
      for (int k = 0; k < NC; k++) begin
        mv_fall[k] = m_coin_prev[k] && !m_deb[PB + k];
        if (mv_rd && mv_addr == 'h13 + 2 * k) m_coin[k] = mv_fall[k] ? 1 : 0;
        else if (mv_fall[k] && m_coin[k] < 255) m_coin[k] = m_coin[k] + 1;
        if (mv_wr && mv_addr == 'h1B && DI[k]) m_meter[k] = MLEN;
        else if (m_meter[k] > 0) m_meter[k] = m_meter[k] - 1;
        m_coin_prev[k] = m_deb[PB + k];
      end
      if (mv_rd) m_do = mv_rv;
      if (mv_wr) begin
        if (mv_addr < 1 + 2 * NP) m_out[(mv_addr - 1) / 2] = DI;
        if (mv_addr == 'h11) m_dir = DI;
      end
      // A bit adopts its synchronised level once that level has disagreed
      // with it for DEB consecutive CE_R ticks.
      for (int b = 0; b < NB; b++) begin
        if (m_s2[b] == m_deb[b]) m_run[b] = 0;
        else if (CE_R) begin
          m_run[b] = m_run[b] + 1;
          if (m_run[b] == DEB) begin
            m_deb[b] = m_s2[b];
            m_run[b] = 0;
          end
        end
      end
      for (int b = 0; b < NB; b++) begin
        m_s2[b] = m_s1[b];
        m_s1[b] = (b < PB) ? PIN_IN[b] : COIN_N[b - PB];
      end
      m_rw_old = RW_N;
      m_cs_old = CS_N;
    end
  end

  // Per-cycle compare of every output against the model.
  logic [PB-1:0] e_out;
  logic [NP-1:0] e_oe;
  logic [NC-1:0] e_met;
  always @(negedge CLK) begin
    if (m_started) begin
      for (int i = 0; i < NP; i++) begin
        e_out[8*i +: 8] = m_out[i];
        e_oe[i]         = ~m_dir[i];
      end
      for (int k = 0; k < NC; k++) e_met[k] = (m_meter[k] != 0);
      chk("do_model", DO, m_do);
      chk("pin_out_model", PIN_OUT, e_out);
      chk("pin_oe_model", PIN_OE, e_oe);
      chk("coin_meter_model", COIN_METER, e_met);
    end
  end

  // Length of the most recent COIN_METER[0] pulse, in cycles.
  int run_len = 0;
  int last_len = 0;
  always @(negedge CLK) begin
    if (COIN_METER[0]) run_len++;
    else begin
      if (run_len != 0) last_len = run_len;
      run_len = 0;
    end
  end

  // ---------------- bus helpers (start and end on a negedge) ----------------
  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    A = addr[6:1]; DI = data; CS_N = 0; RW_N = 0;
    @(negedge CLK);
    CS_N = 1; RW_N = 1;
    @(negedge CLK);
  endtask

  task automatic rd(input logic [7:0] addr, output logic [7:0] data);
    A = addr[6:1]; CS_N = 0; RW_N = 1;
    @(negedge CLK);
    data = DO;
    CS_N = 1;
    @(negedge CLK);
  endtask

  task automatic coin_pulse(input int lo, input int hi);
    COIN_N[0] = 0;
    repeat (lo) @(negedge CLK);
    COIN_N[0] = 1;
    repeat (hi) @(negedge CLK);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] r;

  initial begin
    RST = 1; CE_R = 1; A = 0; DI = 0; CS_N = 1; RW_N = 1;
    PIN_IN = '1; COIN_N = '1;
    repeat (3) @(negedge CLK);
    RST = 0;
    @(negedge CLK);

    // reset state
    rd(8'h11, r); chk("reset_dir", r, 8'hFF);
    rd(8'h01, r); chk("reset_port0", r, 8'hFF);
    rd(8'h1B, r); chk("reset_meter_read", r, 8'hFF);
    chk("reset_oe", PIN_OE, 0);
    chk("reset_meter", COIN_METER, 0);

    // direction / output masking
    wr(8'h11, 8'hF7);
    wr(8'h07, 8'h5A);
    chk("dir_oe", PIN_OE, 7'h08);
    chk("port3_out", PIN_OUT[31:24], 8'h5A);
    rd(8'h07, r); chk("port3_read", r, 8'h5A);

    // debounce: short glitch rejected, long press accepted
    PIN_IN[0] = 0; repeat (3) @(negedge CLK);
    PIN_IN[0] = 1; repeat (10) @(negedge CLK);
    rd(8'h01, r); chk("deb_glitch", r, 8'hFF);
    PIN_IN[0] = 0; repeat (8) @(negedge CLK);
    rd(8'h01, r); chk("deb_press", r, 8'hFE);
    PIN_IN[0] = 1; repeat (10) @(negedge CLK);

    // coin counting, clear on read, saturation
    repeat (3) coin_pulse(8, 8);
    rd(8'h13, r); chk("coin_three", r, 8'h03);
    rd(8'h13, r); chk("coin_cleared", r, 8'h00);
    repeat (300) coin_pulse(6, 6);
    rd(8'h13, r); chk("coin_saturate", r, 8'hFF);

    // coin edge coinciding with the clearing read
    repeat (2) coin_pulse(8, 8);
    COIN_N[0] = 0;
    repeat (6) @(negedge CLK);
    rd(8'h13, r); chk("coin_coincide_old", r, 8'h02);
    COIN_N[0] = 1; repeat (10) @(negedge CLK);
    rd(8'h13, r); chk("coin_coincide_next", r, 8'h01);

    // meter pulse, retrigger, reset abort
    wr(8'h1B, 8'h01);
    repeat (20) @(negedge CLK);
    chk("meter_len", last_len, 16);
    wr(8'h1B, 8'h01);
    repeat (8) @(negedge CLK);
    wr(8'h1B, 8'h01);
    repeat (30) @(negedge CLK);
    chk("meter_retrigger", last_len, 26);
    wr(8'h1B, 8'hFC);
    chk("meter_high_bits", COIN_METER, 0);
    wr(8'h1B, 8'h01);
    repeat (3) @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    chk("meter_reset", COIN_METER, 0);
    RST = 0;
    repeat (2) @(negedge CLK);
    chk("meter_reset_len", last_len, 5);

    // unmapped / unimplemented
    wr(8'h0F, 8'h00);
    rd(8'h0F, r); chk("unimpl_port", r, 8'hFF);
    rd(8'h21, r); chk("unmapped", r, 8'hFF);

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      CE_R = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) PIN_IN[$urandom_range(0, PB - 1)] ^= 1'b1;
      for (int k = 0; k < NC; k++) if ($urandom_range(0, 7) == 0) COIN_N[k] = ~COIN_N[k];
      if ($urandom_range(0, 1) == 0) begin
        CS_N = 1'($urandom_range(0, 1));
        RW_N = 1'($urandom_range(0, 1));
        A    = 6'($urandom_range(0, 17));
        DI   = 8'($urandom);
      end
      RST = ($urandom_range(0, 999) == 0);
      @(negedge CLK);
    end
    RST = 0; CS_N = 1; RW_N = 1; CE_R = 1;
    repeat (5) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stv_io_ports_gen.md
Name: stv_io_ports_gen

Overview:
Parametrised second-generation ST-V I/O port block for the Saturn/ST-V core. It provides up to 8 bidirectional 8-bit ports behind the same byte-wide CS_N/RW_N register interface and the same port-direction model. New behaviour:
- synchronised, debounced pin inputs;
- saturating coin counters that clear on read;
- retriggerable coin-meter pulse outputs.

It sits between the SH-2 I/O chip-select decode and the JAMMA/extension pin mapping in the top level.

Parameters:
NUM_PORTS, 7, number of 8-bit ports implemented (1..8).
NUM_COIN, 2, number of coin channels (1..4).
DEB_CYC, 4, debounce length in CE_R ticks (0 = bypass, 1..15).
METER_LEN, 1024, coin-meter pulse length in CLK cycles (1..65535).

Ports:
CLK  in  1  system clock.
RST  in  1  reset, synchronous, active-high.
CE_R  in  1  debounce tick enable.
A  in  6  byte address bits [6:1]; the register address is {A,1'b1}.
DI  in  8  write data.
DO  out  8  read data (registered).
CS_N  in  1  chip select, active-low.
RW_N  in  1  1 = read, 0 = write.
PIN_IN  in  8*NUM_PORTS  raw port pins; port i occupies bits [8i+7:8i]; active-low buttons.
PIN_OUT  out  8*NUM_PORTS  output latches, same packing as PIN_IN.
PIN_OE  out  NUM_PORTS  per-port output enable, equal to ~DIR.
COIN_N  in  NUM_COIN  raw coin switches, active-low.
COIN_METER  out  NUM_COIN  coin-meter drive, active-high.

Behaviour:
- One clock, CLK. Reset is synchronous and active-high on RST.
- Reset values, applied on the first CLK edge with RST=1 and overriding all other activity:
  - OUT = all FF; DIR = all 1 (PIN_OE = 0).
  - DO = 00.
  - synchroniser and debounced state = all 1; debounce counters = 0.
  - coin counts = 0; meter counters = 0 (COIN_METER = 0).
  - RW_N_OLD = 1, CS_N_OLD = 1.
- Write strobe: RW_N_OLD=1 && RW_N=0 && CS_N=0. The register updates on that same edge.
- Read strobe: CS_N_OLD=1 && CS_N=0 && RW_N=1. DO is valid from the next cycle and holds until the next read strobe.
- Address map:
  - 0x01 + 2i: port i, for i < NUM_PORTS.
  - 0x11: DIR.
  - 0x13 + 2k: coin count k, for k < NUM_COIN.
  - 0x1B: METER (write-only).
  - Every other address, including unimplemented ports and coins: reads return FF, writes are ignored. A read of METER returns FF.
- Port read value: DEB[i] & (OUT[i] | {8{DIR[i]}}).
- Input path:
  - Two-flop synchroniser on every PIN_IN and COIN_N bit.
  - Each bit has a 4-bit debounce counter.
  - On a CE_R=1 cycle where the synchronised value ≠ DEB, the counter increments. When it reaches DEB_CYC, DEB takes the new value and the counter clears.
  - Any cycle where synchronised == DEB clears the counter.
  - DEB_CYC=0: DEB = synchronised value, giving 2 cycles of pin latency.
- Coin count k:
  - An 8-bit counter increments on the debounced COIN_N 1→0 transition and saturates at FF.
  - A read strobe to its address loads DO with the pre-clear value and clears the counter.
  - If an increment coincides with the clearing read: DO = old value and the counter becomes 01.
- Coin meter:
  - A write to 0x1B with DI[k]=1 loads meter counter k with METER_LEN.
  - COIN_METER[k] = (counter k ≠ 0); the counter decrements by 1 every CLK cycle while nonzero.
  - Writing a 1 while the pulse is active restarts the count (retrigger).
  - DI bits ≥ NUM_COIN are ignored.
- Simultaneous events:
  - A write strobe and a read strobe cannot coexist because RW_N differs.
  - RST asserted mid-pulse or mid-debounce aborts it immediately.

Test Plan:
- Reset: after RST, read 0x11 → FF, read 0x01 with PIN_IN=FF → FF, read 0x1B → FF, PIN_OE=0, COIN_METER=0.
- Direction/output masking: write DIR=F7, write 0x07=5A → PIN_OE[3]=1 and PIN_OUT[31:24]=5A. With PIN_IN[31:24]=FF, read 0x07 → 5A.
- Debounce (DEB_CYC=4, CE_R every cycle):
  - PIN_IN[0] low for 3 cycles, then high → read 0x01 = FF.
  - Held low ≥ 6 cycles → read 0x01 = FE.
- Coin counting:
  - Three clean COIN_N[0] low pulses → read 0x13 = 03, then read 0x13 = 00.
  - 300 pulses → read 0x13 = FF (saturated).
  - A coin edge on the same cycle as the read → DO = old value, next read = 01.
- Meter (METER_LEN=16):
  - Write 0x1B=01 → COIN_METER[0] high for exactly 16 cycles.
  - Rewrite at cycle 10 → high for 26 cycles total.
  - RST at cycle 5 → low on the next cycle.
- Unmapped/unimplemented access (NUM_PORTS=7): write 0x0F=00, then read 0x0F → FF. Read 0x21 → FF.
